// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Presents one BCD digit at a time with guard blanking, leading-zero suppression and frame-aligned loads.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int NUM_DIGITS  = 8,
    parameter int GUARD       = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        load_ack,
    output logic [2:0]  digit_sel,
    output logic [3:0]  bcd,
    output logic        dec_en,
    output logic        frame_start,
    output logic        bad_digit
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   pendingBuf_q, pendingBuf_d;
    logic          pending_q, pending_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          decEn_q, decEn_d;
    logic          loadAck_q, loadAck_d;
    logic          frameStart_q, frameStart_d;
    logic          badDigit_q, badDigit_d;

    logic          wrap;
    logic          frameEntry;
    logic [3:0]    nib;
    logic [7:0]    zeroAbove;
    logic          runZero;
    logic          suppress;

    // Next-state logic; output registers are computed from the state being entered,
    // so every output lines up with the slot that starts on the same edge.
    always_comb begin
        wrap         = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d        = wrap ? '0 : cnt_q + CW'(1);
        idx_d        = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        frameEntry   = wrap && (idx_d == 3'd0);

        shadow_d     = shadow_q;
        pendingBuf_d = pendingBuf_q;
        pending_d    = pending_q;
        if (frameEntry && pending_q) begin
            shadow_d  = pendingBuf_q;
            pending_d = 1'b0;
        end
        // A load in the commit cycle becomes the next pending value.
        if (load) begin
            pendingBuf_d = value;
            pending_d    = 1'b1;
        end

        zeroAbove = '0;
        runZero   = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (k < NUM_DIGITS) begin
                runZero      = runZero && (shadow_d[k*4 +: 4] == 4'd0);
                zeroAbove[k] = runZero;
            end
        end

        nib          = shadow_d[{idx_d, 2'b00} +: 4];
        suppress     = (LZ_SUPPRESS != 0) && (idx_d != 3'd0) && zeroAbove[idx_d];
        bcd_d        = nib;
        decEn_d      = (int'(cnt_d) >= GUARD) && (nib <= 4'd9) && !suppress;
        loadAck_d    = frameEntry && pending_q;
        frameStart_d = frameEntry;
        badDigit_d   = badDigit_q || (wrap && (nib > 4'd9));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= '0;
            pendingBuf_q <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= 4'd0;
            decEn_q      <= 1'b0;
            loadAck_q    <= 1'b0;
            frameStart_q <= 1'b0;
            badDigit_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pendingBuf_q <= pendingBuf_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            decEn_q      <= decEn_d;
            loadAck_q    <= loadAck_d;
            frameStart_q <= frameStart_d;
            badDigit_q   <= badDigit_d;
        end
    end

    assign digit_sel   = idx_q;
    assign bcd         = bcd_q;
    assign dec_en      = decEn_q;
    assign load_ack    = loadAck_q;
    assign frame_start = frameStart_q;
    assign bad_digit   = badDigit_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: free-run after reset, a chain of frame-table vectors
// (each frame checks the live display while loading the next value), and a reset-discards-load sequence.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;
    localparam int ND = 4;
    localparam int GD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;

    logic        load_ack, dec_en, frame_start, bad_digit;
    logic [2:0]  digit_sel;
    logic [3:0]  bcd;
    logic        nlzLoadAck, nlzDecEn, nlzFrameStart, nlzBadDigit;
    logic [2:0]  nlzDigitSel;
    logic [3:0]  nlzBcd;

    int numChecks = 0;
    int numFails  = 0;
    string curTag = "";

    typedef struct {
        logic [15:0] shown;
        logic [3:0]  lit;
        logic [3:0]  litNoLz;
        logic        ack;
        int          badSlot;
        logic [31:0] valA;
        int          kA;
        logic [31:0] valB;
        int          kB;
    } frameVec_t;

    frameVec_t frames[8];

    seg7_scan_ctrl #(.SCAN_DIV(SD), .NUM_DIGITS(ND), .GUARD(GD), .LZ_SUPPRESS(1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .load_ack(load_ack), .digit_sel(digit_sel), .bcd(bcd), .dec_en(dec_en),
        .frame_start(frame_start), .bad_digit(bad_digit)
    );

    seg7_scan_ctrl #(.SCAN_DIV(SD), .NUM_DIGITS(ND), .GUARD(GD), .LZ_SUPPRESS(0)) dutNoLz (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .load_ack(nlzLoadAck), .digit_sel(nlzDigitSel), .bcd(nlzBcd), .dec_en(nlzDecEn),
        .frame_start(nlzFrameStart), .bad_digit(nlzBadDigit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s %s: got %0h, expected %0h at %0t", curTag, name, act, exp, $time);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst digit_sel", 32'(digit_sel), 32'd0);
        checkOutput("rst bcd", 32'(bcd), 32'd0);
        checkOutput("rst dec_en", 32'(dec_en), 32'd0);
        checkOutput("rst load_ack", 32'(load_ack), 32'd0);
        checkOutput("rst frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst bad_digit", 32'(bad_digit), 32'd0);
    endtask

    // Starts on the negedge right after the reset edge; display value is zero throughout.
    task automatic freeRun(input int n);
        for (int k = 0; k < n; k++) begin
            int slot;
            int cyc;
            slot = (k / SD) % ND;
            cyc  = k % SD;
            checkOutput("free digit_sel", 32'(digit_sel), 32'(slot));
            checkOutput("free bcd", 32'(bcd), 32'd0);
            checkOutput("free dec_en", 32'(dec_en), 32'((slot == 0) && (cyc >= GD)));
            checkOutput("free frame_start", 32'(frame_start), 32'((k % (SD * ND) == 0) && (k != 0)));
            checkOutput("free load_ack", 32'(load_ack), 32'd0);
            checkOutput("free bad_digit", 32'(bad_digit), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic waitFrameStart();
        int budget;
        budget = 0;
        while (frame_start !== 1'b1 && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        if (frame_start !== 1'b1) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL waitFrameStart: got no frame_start, expected one within 64 cycles");
        end
    endtask

    // Checks one whole frame against a table entry while driving that entry's loads.
    task automatic applyStimulus(input frameVec_t fv);
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < SD; c++) begin
                int k;
                k = s * SD + c;
                checkOutput("digit_sel", 32'(digit_sel), 32'(s));
                checkOutput("bcd", 32'(bcd), 32'(fv.shown[s*4 +: 4]));
                checkOutput("dec_en", 32'(dec_en), 32'((c >= GD) && fv.lit[s]));
                checkOutput("dec_en noLz", 32'(nlzDecEn), 32'((c >= GD) && fv.litNoLz[s]));
                checkOutput("load_ack", 32'(load_ack), 32'(fv.ack && (k == 0)));
                checkOutput("frame_start", 32'(frame_start), 32'(k == 0));
                checkOutput("bad_digit", 32'(bad_digit), 32'(s >= fv.badSlot));
                load  = (k == fv.kA) || (k == fv.kB);
                value = (k == fv.kB) ? fv.valB : fv.valA;
                @(negedge clk);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 32'd0;

        frames[0] = '{16'h0000, 4'b0001, 4'b1111, 1'b0, 4, 32'h0000_1234, 5, 32'h0, -1};
        frames[1] = '{16'h1234, 4'b1111, 4'b1111, 1'b1, 4, 32'h0000_0105, 5, 32'h0, -1};
        frames[2] = '{16'h0105, 4'b0111, 4'b1111, 1'b1, 4, 32'h0000_0A07, 5, 32'h0, -1};
        frames[3] = '{16'h0A07, 4'b0011, 4'b1011, 1'b1, 2, 32'h0000_0007, 5, 32'h0, -1};
        frames[4] = '{16'h0007, 4'b0001, 4'b1111, 1'b1, 0, 32'h0000_1111, 5, 32'h0000_2222, 8};
        frames[5] = '{16'h2222, 4'b1111, 4'b1111, 1'b1, 0, 32'h0000_3333, 5, 32'h0000_4444, 15};
        frames[6] = '{16'h3333, 4'b1111, 4'b1111, 1'b1, 0, 32'h0, -1, 32'h0, -1};
        frames[7] = '{16'h4444, 4'b1111, 4'b1111, 1'b1, 0, 32'h0, -1, 32'h0, -1};

        @(posedge clk);
        @(negedge clk);
        curTag = "reset";
        checkReset();
        rst = 1'b0;
        curTag = "freerun";
        freeRun(40);

        waitFrameStart();
        for (int i = 0; i < 8; i++) begin
            curTag = $sformatf("frame%0d", i);
            applyStimulus(frames[i]);
        end

        // Load mid-frame, then reset before the boundary: the load must vanish.
        curTag = "rstdrop";
        for (int k = 0; k < 14; k++) begin
            checkOutput("load_ack", 32'(load_ack), 32'd0);
            load  = (k == 5);
            value = 32'h0000_9999;
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        freeRun(40);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
